// File: rtl/sha_nonce_sweep_pre_pipeline.sv
// SHA-256 second-block pre-pipeline: nonce sweep (start/step/wrap), stall
// back-pressure, and the first ROUNDS compression rounds as registered stages.
module sha_nonce_sweep_pre_pipeline #(
  parameter int unsigned ROUNDS      = 16,
  parameter logic [31:0] NONCE_START = 32'd0,
  parameter logic [31:0] NONCE_STEP  = 32'd1,
  parameter logic [31:0] MSG_BITS    = 32'd640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [255:0]      state_in,
  input  logic [31:0]       w1,
  input  logic [31:0]       w2,
  input  logic [31:0]       w3,
  input  logic              stall_i,
  output logic              output_valid,
  output logic              newblock_o,
  output logic [31:0]       nonce_o,
  output logic [15:0][31:0] history,
  output logic [255:0]      state_out,
  output logic              exhausted_o
);

  localparam int unsigned CTR_W = 33;
  localparam int unsigned ST_W  = 256;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

  fsm_t             fsm_q;
  logic [CTR_W-1:0] ctr_q;
  logic [CTR_W-1:0] ctr_sum;
  logic             first_q;
  logic [ST_W-1:0]  mid_q;
  logic [31:0]      w1_q, w2_q, w3_q;
  logic             issue;

  logic [ROUNDS-1:0] st_valid;
  logic [ROUNDS-1:0] st_nb;
  logic [ROUNDS-1:0] valid_nxt;
  logic [ST_W-1:0]   st_state [ROUNDS];
  logic [31:0]       st_nonce [ROUNDS];
  logic [ST_W-1:0]   rnd      [ROUNDS];

  // Round constants K[0..15]
  function automatic logic [31:0] k_const(input logic [3:0] idx);
    logic [31:0] k;
    case (idx)
      4'd0:    k = 32'h428a2f98;
      4'd1:    k = 32'h71374491;
      4'd2:    k = 32'hb5c0fbcf;
      4'd3:    k = 32'he9b5dba5;
      4'd4:    k = 32'h3956c25b;
      4'd5:    k = 32'h59f111f1;
      4'd6:    k = 32'h923f82a4;
      4'd7:    k = 32'hab1c5ed5;
      4'd8:    k = 32'hd807aa98;
      4'd9:    k = 32'h12835b01;
      4'd10:   k = 32'h243185be;
      4'd11:   k = 32'h550c7dc3;
      4'd12:   k = 32'h72be5d74;
      4'd13:   k = 32'h80deb1fe;
      4'd14:   k = 32'h9bdc06a7;
      default: k = 32'hc19bf174;
    endcase
    return k;
  endfunction

  // Message word W[idx] of a job; only W3 varies per job
  function automatic logic [31:0] msg_word(input logic [3:0] idx, input logic [31:0] nonce,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    logic [31:0] w;
    case (idx)
      4'd0:    w = a;
      4'd1:    w = b;
      4'd2:    w = c;
      4'd3:    w = nonce;
      4'd4:    w = 32'h80000000;
      4'd15:   w = MSG_BITS;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // One SHA-256 compression round, state packed as {a,b,c,d,e,f,g,h}
  function automatic logic [ST_W-1:0] sha_round(input logic [ST_W-1:0] s,
                                                input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + ({e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]})
           + ((e & f) ^ (~e & g)) + k + w;
    t2 = ({a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]})
       + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  assign issue   = (fsm_q == RUN) && !stall_i && !start_i;
  assign ctr_sum = ctr_q + {1'b0, NONCE_STEP};

  // Stage valid vector after an unstalled advance
  always_comb begin
    valid_nxt    = '0;
    valid_nxt[0] = issue;
    for (int unsigned i = 1; i < ROUNDS; i++) valid_nxt[i] = st_valid[i-1];
  end

  // Round logic feeding each stage register
  always_comb begin
    rnd[0] = sha_round(mid_q, k_const(4'd0), msg_word(4'd0, ctr_q[31:0], w1_q, w2_q, w3_q));
    for (int unsigned i = 1; i < ROUNDS; i++)
      rnd[i] = sha_round(st_state[i-1], k_const(4'(i)),
                         msg_word(4'(i), st_nonce[i-1], w1_q, w2_q, w3_q));
  end

  // Sweep control: block capture, nonce counter, run/drain/exhaust FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      ctr_q       <= '0;
      first_q     <= 1'b0;
      exhausted_o <= 1'b0;
      mid_q       <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      w3_q        <= '0;
    end else begin
      exhausted_o <= 1'b0;
      if (start_i) begin
        mid_q   <= state_in;
        w1_q    <= w1;
        w2_q    <= w2;
        w3_q    <= w3;
        ctr_q   <= {1'b0, NONCE_START};
        first_q <= 1'b1;
        fsm_q   <= RUN;
      end else if (!stall_i) begin
        case (fsm_q)
          RUN: begin
            ctr_q   <= ctr_sum;
            first_q <= 1'b0;
            if (ctr_sum[CTR_W-1]) fsm_q <= DRAIN;
          end
          DRAIN: begin
            if (valid_nxt == '0) begin
              exhausted_o <= 1'b1;
              fsm_q       <= IDLE;
            end
          end
          default: fsm_q <= fsm_q;
        endcase
      end
    end
  end

  // Round stages; start flushes in-flight jobs, stall freezes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= '0;
      st_nb    <= '0;
      for (int unsigned i = 0; i < ROUNDS; i++) begin
        st_state[i] <= '0;
        st_nonce[i] <= '0;
      end
    end else if (start_i) begin
      st_valid <= '0;
      st_nb    <= '0;
    end else if (!stall_i) begin
      st_valid    <= valid_nxt;
      st_nb[0]    <= issue & first_q;
      st_state[0] <= rnd[0];
      st_nonce[0] <= ctr_q[31:0];
      for (int unsigned i = 1; i < ROUNDS; i++) begin
        st_nb[i]    <= st_nb[i-1];
        st_state[i] <= rnd[i];
        st_nonce[i] <= st_nonce[i-1];
      end
    end
  end

  assign output_valid = st_valid[ROUNDS-1];
  assign newblock_o   = st_nb[ROUNDS-1];
  assign nonce_o      = st_nonce[ROUNDS-1];
  assign state_out    = st_state[ROUNDS-1];

  // Message history of the output job, held at zero while no job is valid
  always_comb begin
    history = '0;
    if (output_valid) begin
      history[15] = w1_q;
      history[14] = w2_q;
      history[13] = w3_q;
      history[12] = nonce_o;
      history[11] = 32'h80000000;
      history[0]  = MSG_BITS;
    end
  end

endmodule

// File: tb/tb_sha_nonce_sweep_pre_pipeline.sv
// Bench for sha_nonce_sweep_pre_pipeline: three parameterisations share stimulus,
// each with its own reference model and scoreboard queue.
module tb_sha_nonce_sweep_pre_pipeline;

  typedef struct {
    int               due;
    logic             nb;
    logic [31:0]      nonce;
    logic [255:0]     st;
    logic [15:0][31:0] hist;
  } exp_t;

  localparam logic [31:0] K_TAB [16] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};

  localparam logic [255:0] SHA_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic [255:0] st_in = '0;
  logic [31:0]  w1 = '0, w2 = '0, w3 = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] m_round(input logic [255:0] s, input logic [31:0] k,
                                           input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [255:0] model_state(input logic [255:0] s0, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] c,
                                               input logic [31:0] n, input int r);
    logic [31:0]  wm [16];
    logic [255:0] s;
    for (int i = 0; i < 16; i++) wm[i] = 32'h0;
    wm[0] = a; wm[1] = b; wm[2] = c; wm[3] = n;
    wm[4] = 32'h80000000; wm[15] = 32'd640;
    s = s0;
    for (int i = 0; i < r; i++) s = m_round(s, K_TAB[i], wm[i]);
    return s;
  endfunction

  function automatic logic [15:0][31:0] model_hist(input logic [31:0] a, input logic [31:0] b,
                                                   input logic [31:0] c, input logic [31:0] n);
    logic [15:0][31:0] h;
    h = '0;
    h[15] = a; h[14] = b; h[13] = c; h[12] = n;
    h[11] = 32'h80000000; h[0] = 32'd640;
    return h;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned R     = (g == 0) ? 16 : ((g == 1) ? 1 : 4);
    localparam logic [31:0] NS    = (g == 0) ? 32'd0 : ((g == 1) ? 32'd3 : 32'hFFFFFFFC);
    localparam logic [31:0] NSTEP = (g == 0) ? 32'd1 : ((g == 1) ? 32'd4 : 32'd2);

    logic              ov, nb, exh;
    logic [31:0]       no;
    logic [15:0][31:0] hist;
    logic [255:0]      so;

    sha_nonce_sweep_pre_pipeline #(
      .ROUNDS(R), .NONCE_START(NS), .NONCE_STEP(NSTEP), .MSG_BITS(32'd640)
    ) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .state_in(st_in),
      .w1(w1), .w2(w2), .w3(w3), .stall_i(stall),
      .output_valid(ov), .newblock_o(nb), .nonce_o(no), .history(hist),
      .state_out(so), .exhausted_o(exh)
    );

    exp_t         q[$];
    int           adv = 0;
    int           mode = 0;
    logic [32:0]  mctr = '0;
    logic         mfirst = 1'b0;
    logic         exp_exh = 1'b0;
    logic [255:0] cst = '0;
    logic [31:0]  c1 = '0, c2 = '0, c3 = '0;

    // Reference model: mode 0 idle, 1 run, 2 drain; scoreboard entries carry due cycle
    always @(posedge clk or negedge rst) begin
      exp_t e;
      if (!rst) begin
        q.delete();
        mode    = 0;
        mfirst  = 1'b0;
        exp_exh = 1'b0;
      end else begin
        exp_exh = 1'b0;
        if (start) begin
          q.delete();
          mode   = 1;
          mctr   = {1'b0, NS};
          mfirst = 1'b1;
          cst = st_in; c1 = w1; c2 = w2; c3 = w3;
        end else if (!stall) begin
          if (q.size() > 0 && q[0].due == adv) void'(q.pop_front());
          adv++;
          if (mode == 1) begin
            e.due   = adv + int'(R) - 1;
            e.nb    = mfirst;
            e.nonce = mctr[31:0];
            e.st    = model_state(cst, c1, c2, c3, mctr[31:0], int'(R));
            e.hist  = model_hist(c1, c2, c3, mctr[31:0]);
            q.push_back(e);
            mfirst = 1'b0;
            mctr   = mctr + {1'b0, NSTEP};
            if (mctr[32]) mode = 2;
          end else if (mode == 2 && q.size() == 0) begin
            exp_exh = 1'b1;
            mode    = 0;
          end
        end
      end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
      if (rst) begin
        if (q.size() > 0 && q[0].due == adv) begin
          chk($sformatf("d%0d.valid", g), 512'(ov), 512'(1'b1));
          chk($sformatf("d%0d.newblock", g), 512'(nb), 512'(q[0].nb));
          chk($sformatf("d%0d.nonce", g), 512'(no), 512'(q[0].nonce));
          chk($sformatf("d%0d.state", g), 512'(so), 512'(q[0].st));
          chk($sformatf("d%0d.history", g), 512'(hist), 512'(q[0].hist));
        end else begin
          chk($sformatf("d%0d.idle_valid", g), 512'(ov), 512'(1'b0));
        end
        chk($sformatf("d%0d.exhausted", g), 512'(exh), 512'(exp_exh));
      end
    end

    // Asynchronous reset clears every output without a clock edge
    always @(negedge rst) begin
      #1;
      chk($sformatf("d%0d.rst_valid", g), 512'(ov), 512'(1'b0));
      chk($sformatf("d%0d.rst_newblock", g), 512'(nb), 512'(1'b0));
      chk($sformatf("d%0d.rst_nonce", g), 512'(no), 512'(32'h0));
      chk($sformatf("d%0d.rst_state", g), 512'(so), 512'(256'h0));
      chk($sformatf("d%0d.rst_history", g), 512'(hist), 512'(0));
      chk($sformatf("d%0d.rst_exhausted", g), 512'(exh), 512'(1'b0));
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    // Basic sweep from the SHA-256 IV with zero message words
    st_in = SHA_IV; w1 = 32'h0; w2 = 32'h0; w3 = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    // Stall window mid-sweep
    stall = 1'b1;
    repeat (5) @(negedge clk);
    stall = 1'b0;
    repeat (20) @(negedge clk);
    // Reset asserted between clock edges
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    // Random block, then restart five cycles later with a new w2
    st_in = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
             32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    w1 = 32'($urandom); w2 = 32'($urandom); w3 = 32'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    w2 = w2 ^ 32'h12345678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    stall = 1'b0;
    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
